// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// The clear sequence and the round-robin grant are the two FSM phases.
package regfile_wb_arbiter_pkg;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_NUM = 32;

  typedef enum logic {
    WB_INIT = 1'b0,
    WB_RUN  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward (mod NREQ) and
// returns a one-hot grant plus the encoded index of the winner.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the single regfile write port: clears x1..x(REG_NUM-1) after reset or
// soft_init, then shares the port round-robin among NREQ writeback sources.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_init,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   we_o,
  output logic [ADDR_W-1:0]      waddr_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic                   init_done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_state_e          state_reg;
  logic [ADDR_W-1:0]  clr_ptr_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic               we_reg;
  logic [ADDR_W-1:0]  waddr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic               init_done_reg;

  logic [NREQ-1:0]    gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               hs;
  logic [ADDR_W-1:0]  addr_arr [NREQ];
  logic [DATA_W-1:0]  data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr_reg),
    .grant(gnt),
    .idx  (gnt_idx)
  );

  // soft_init pre-empts any grant in the cycle it is seen
  assign req_ready   = (state_reg == WB_RUN && !soft_init) ? gnt : '0;
  assign hs          = |(req_valid & req_ready);
  assign rr_ptr_next = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= WB_INIT;
      clr_ptr_reg   <= ADDR_W'(1);
      rr_ptr_reg    <= '0;
      we_reg        <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        WB_INIT: begin
          if (soft_init) begin
            clr_ptr_reg <= ADDR_W'(1);
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
          end else begin
            we_reg    <= 1'b1;
            waddr_reg <= clr_ptr_reg;
            wdata_reg <= '0;
            if (clr_ptr_reg == ADDR_W'(REG_NUM - 1)) begin
              state_reg     <= WB_RUN;
              init_done_reg <= 1'b1;
            end else begin
              clr_ptr_reg <= clr_ptr_reg + 1'b1;
            end
          end
        end
        WB_RUN: begin
          if (soft_init) begin
            state_reg     <= WB_INIT;
            clr_ptr_reg   <= ADDR_W'(1);
            init_done_reg <= 1'b0;
            we_reg        <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
          end else if (hs) begin
            // a write to x0 still consumes the grant but never reaches the regfile
            we_reg     <= (addr_arr[gnt_idx] != '0);
            waddr_reg  <= addr_arr[gnt_idx];
            wdata_reg  <= data_arr[gnt_idx];
            rr_ptr_reg <= rr_ptr_next;
          end else begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
          end
        end
        default: state_reg <= WB_INIT;
      endcase
    end
  end

  assign we_o      = we_reg;
  assign waddr_o   = waddr_reg;
  assign wdata_o   = wdata_reg;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sequence, round-robin grants,
// same-address ordering, x0 discard, soft_init and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        soft_init;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        init_done;

  logic [31:0] shadow_rf [32];
  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(
    .NREQ(2), .ADDR_W(5), .DATA_W(32), .REG_NUM(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_init(soft_init),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .we_o     (we_o),
    .waddr_o  (waddr_o),
    .wdata_o  (wdata_o),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // advance one rising edge, sample 1 time unit later, mirror regfile writes
  task automatic step();
    @(posedge clk);
    #1;
    if (we_o === 1'b1) shadow_rf[waddr_o] = wdata_o;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) shadow_rf[i] = 32'hCAFE_0000;
    rst       = 1'b1;
    soft_init = 1'b0;
    set_req(2'b11, 5'd4, 32'h44, 5'd6, 32'h66);
    #2 rst = 1'b0;
    #1;
    check_val("reset_out", {we_o, waddr_o, wdata_o, init_done, req_ready}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1. clear sequence x1..x31, requests held off throughout
    for (int k = 1; k <= 31; k++) begin
      check_val($sformatf("init_ready_%0d", k), {62'd0, req_ready}, 64'd0);
      step();
      check_val($sformatf("init_wr_%0d", k), {we_o, waddr_o, wdata_o},
                {1'b1, 5'(k), 32'd0});
      check_val($sformatf("init_done_%0d", k), {63'd0, init_done}, {63'd0, (k == 31)});
    end
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    check_val("run_idle", {we_o, init_done}, 64'b01);

    // 2. single requester 0, rr_ptr=0
    set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    #1 check_val("t2_ready", {62'd0, req_ready}, 64'b01);
    step();
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_val("t2_write", {we_o, waddr_o, wdata_o}, {1'b1, 5'd5, 32'hDEADBEEF});

    // requester 1 alone, rr_ptr back to 0
    set_req(2'b10, 5'd0, 32'd0, 5'd1, 32'hA5);
    #1 check_val("t2b_ready", {62'd0, req_ready}, 64'b10);
    step();
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_val("t2b_write", {we_o, waddr_o, wdata_o}, {1'b1, 5'd1, 32'hA5});

    // 3. both valid four cycles, grants alternate 0,1,0,1
    set_req(2'b11, 5'd3, 32'h30, 5'd7, 32'h70);
    for (int k = 0; k < 4; k++) begin
      #1 check_val($sformatf("t3_ready_%0d", k), {62'd0, req_ready},
                   (k % 2 == 0) ? 64'b01 : 64'b10);
      step();
      check_val($sformatf("t3_write_%0d", k), {we_o, waddr_o, wdata_o},
                (k % 2 == 0) ? {1'b1, 5'd3, 32'h30} : {1'b1, 5'd7, 32'h70});
    end
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    // move rr_ptr to 1 with one requester-0 write
    set_req(2'b01, 5'd2, 32'h2, 5'd0, 32'd0);
    step();
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    // 4. same address, rr_ptr=1: req1 first, req0 last wins
    set_req(2'b11, 5'd9, 32'h11, 5'd9, 32'h22);
    #1 check_val("t4_ready_a", {62'd0, req_ready}, 64'b10);
    step();
    req_valid = 2'b01;
    check_val("t4_write_a", {we_o, waddr_o, wdata_o}, {1'b1, 5'd9, 32'h22});
    #1 check_val("t4_ready_b", {62'd0, req_ready}, 64'b01);
    step();
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_val("t4_x9", {32'd0, shadow_rf[9]}, 64'h11);
    check_val("t4_x3", {32'd0, shadow_rf[3]}, 64'h30);

    // 5. write to x0 is accepted but discarded
    set_req(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'd0);
    #1 check_val("t5_ready", {62'd0, req_ready}, 64'b01);
    step();
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_val("t5_we", {63'd0, we_o}, 64'd0);
    #1 check_val("t5_no_regrant", {62'd0, req_ready}, 64'b00);

    // 6a. soft_init in RUN pre-empts a valid request
    set_req(2'b01, 5'd4, 32'h44, 5'd0, 32'd0);
    soft_init = 1'b1;
    #1 check_val("t6_si_ready", {62'd0, req_ready}, 64'b00);
    step();
    soft_init = 1'b0;
    set_req(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_val("t6_si_out", {we_o, init_done}, 64'b00);
    for (int k = 1; k <= 11; k++) begin
      step();
      check_val($sformatf("t6_clr_%0d", k), {we_o, waddr_o, wdata_o},
                {1'b1, 5'(k), 32'd0});
    end

    // 6b. async reset with clr_ptr at 12 restarts the clear at x1
    #2 rst = 1'b0;
    #1 check_val("t6_async_rst", {we_o, waddr_o, wdata_o, init_done}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    check_val("t6_restart", {we_o, waddr_o, wdata_o}, {1'b1, 5'd1, 32'd0});
    step();
    check_val("t6_restart2", {we_o, waddr_o}, {1'b1, 5'd2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
